fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 12, PC/instruction-address width in bits.
REQ-002 Parameter INST_W, default 32, instruction width in bits.
REQ-003 Parameter DEPTH, default 4, prefetch buffer entries; power of 2, at least 2.
REQ-004 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-005 Parameter PC_STEP, default 1, PC increment per instruction (word addressing).
REQ-006 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-007 Ports (name  direction  width  meaning):
 clk  in  1  clock, rising edge.
 rst  in  1  asynchronous active-high reset.
 en  in  1  fetch enable; 0 = issue no new requests.
 redir_valid  in  1  redirect (taken branch/jump) this cycle.
 redir_target  in  ADDR_W  redirect target PC.
 imem_req  out  1  memory read request; always accepted.
 imem_addr  out  ADDR_W  request address.
 imem_rvalid  in  1  read response valid; responses return in order, latency 1 or more cycles.
 imem_rdata  in  INST_W  read response data.
 inst_valid  out  1  instruction available at head.
 inst_ready  in  1  consumer accepts head.
 inst_data  out  INST_W  head instruction.
 inst_pc  out  ADDR_W  PC of head instruction.
 err  out  1  sticky protocol error.

Function
REQ-008 State: fetch_pc register; DEPTH-entry circular buffer (pc, data, filled bit per entry) with alloc, fill and head pointers; alloc_cnt (allocated entries); drop_cnt (responses to discard).
REQ-009 Issue condition: en=1, redir_valid=0, alloc_cnt+drop_cnt < DEPTH; imem_req SHALL be combinational from this condition, imem_addr = fetch_pc.
REQ-010 On issue: entry at alloc pointer gets pc=fetch_pc, filled=0; alloc_cnt increments; fetch_pc <= fetch_pc+PC_STEP modulo 2^ADDR_W, wrapping with no flag.
REQ-011 On imem_rvalid with drop_cnt=0 and an unfilled allocated entry: entry at fill pointer gets data=imem_rdata, filled=1.
REQ-012 On imem_rvalid with drop_cnt>0: data discarded, drop_cnt decrements.
REQ-013 On imem_rvalid with drop_cnt=0 and no unfilled entry: response ignored, err <= 1 until reset.
REQ-014 inst_valid = head entry filled and redir_valid=0; inst_data/inst_pc from head entry when inst_valid=1, else all zero.
REQ-015 Pop on inst_valid and inst_ready: head advances, alloc_cnt decrements.
REQ-016 Latency: response sampled at edge N gives inst_valid=1 after edge N; no same-cycle bypass. Peak throughput 1 instruction/cycle.
REQ-017 Simultaneous issue, fill and pop in one cycle SHALL all take effect; alloc_cnt changes by issue minus pop.
REQ-018 Redirect: no issue or pop that cycle; at the edge fetch_pc <= redir_target, all entries invalidated, alloc_cnt <= 0; drop_cnt <= drop_cnt + unfilled allocated entries - (1 if rvalid that cycle, else 0).
REQ-019 Back-to-back redirects: each applies REQ-018; the last target wins.
REQ-020 en=0 SHALL only stop issue; fills, pops and redirects continue.
REQ-021 Buffer full (alloc_cnt=DEPTH) SHALL deassert imem_req; no entry is overwritten.

Reset
REQ-022 rst=1 SHALL immediately force: fetch_pc=RESET_PC, buffer empty, alloc_cnt=0, drop_cnt=0, err=0, imem_req=0, inst_valid=0, inst_data=0, inst_pc=0.
REQ-023 Reset mid-operation SHALL abandon in-flight requests; the bench holds the memory model in reset too.
REQ-024 First request SHALL be issued on the first cycle after rst deasserts with en=1.

Verification (DEPTH=4, ADDR_W=12, PC_STEP=1, RESET_PC=0 unless stated)
REQ-025 Memory latency 1, inst_ready=1, en=1 -> imem_addr 0,1,2,... every cycle; inst_pc 0,1,2,... every cycle, the first two cycles after the first request.
REQ-026 inst_ready=0 -> exactly four requests (addr 0-3), then imem_req=0; raise inst_ready -> pops pc 0,1,2,3 in order, issue resumes at addr 4.
REQ-027 Latency 3, redirect to 0x100 with 2 requests outstanding -> next 2 rvalid discarded, no err; next inst_pc=0x100, then 0x101.
REQ-028 RESET_PC=0xFFE -> imem_addr 0xFFE, 0xFFF, 0x000; inst_pc follows the same wrap.
REQ-029 rst pulsed mid-stream, between clock edges -> all outputs reset without waiting for clk; after release fetch restarts at RESET_PC.
REQ-030 rvalid with no outstanding request -> err=1, stays 1 until reset; buffer contents and inst_valid unchanged.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: issues sequential reads, holds in-order responses in a
// small circular prefetch buffer and hands them out one per cycle; redirects flush it.
module fetch_unit #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned INST_W   = 32,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned PC_STEP  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] OCC_MAX = (CW+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(PC_STEP);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic [INST_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  filled_q;
  ptr_t              alloc_ptr_q, alloc_ptr_d;
  ptr_t              fill_ptr_q, fill_ptr_d;
  ptr_t              head_ptr_q, head_ptr_d;
  cnt_t              alloc_cnt_q, alloc_cnt_d;
  cnt_t              unfill_cnt_q, unfill_cnt_d;
  cnt_t              drop_cnt_q, drop_cnt_d;
  logic              err_q, err_d;

  logic       issue, fill, pop, drop_dec, none_owed;
  logic [CW:0] occ;
  cnt_t        owed;

  // Entries still awaiting data plus responses already marked for discard.
  assign owed      = drop_cnt_q + unfill_cnt_q;
  assign none_owed = (owed == '0);
  assign occ       = {1'b0, alloc_cnt_q} + {1'b0, drop_cnt_q};

  assign issue    = en & ~redir_valid & ~rst & (occ < OCC_MAX);
  assign fill     = imem_rvalid & ~redir_valid & (drop_cnt_q == '0) & (unfill_cnt_q != '0);
  assign drop_dec = imem_rvalid & ~redir_valid & (drop_cnt_q != '0);

  assign imem_req   = issue;
  assign imem_addr  = fetch_pc_q;
  assign inst_valid = filled_q[head_ptr_q] & ~redir_valid;
  assign pop        = inst_valid & inst_ready;
  assign inst_data  = inst_valid ? data_q[head_ptr_q] : '0;
  assign inst_pc    = inst_valid ? pc_q[head_ptr_q] : '0;
  assign err        = err_q;

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    alloc_ptr_d  = alloc_ptr_q;
    fill_ptr_d   = fill_ptr_q;
    head_ptr_d   = head_ptr_q;
    alloc_cnt_d  = alloc_cnt_q;
    unfill_cnt_d = unfill_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    err_d        = err_q | (imem_rvalid & none_owed);
    if (redir_valid) begin
      fetch_pc_d   = redir_target;
      alloc_ptr_d  = '0;
      fill_ptr_d   = '0;
      head_ptr_d   = '0;
      alloc_cnt_d  = '0;
      unfill_cnt_d = '0;
      // A response arriving this cycle retires one outstanding request.
      drop_cnt_d   = owed - cnt_t'(imem_rvalid & ~none_owed);
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + PC_INC;
      alloc_ptr_d  = alloc_ptr_q + ptr_t'(issue);
      fill_ptr_d   = fill_ptr_q + ptr_t'(fill);
      head_ptr_d   = head_ptr_q + ptr_t'(pop);
      alloc_cnt_d  = alloc_cnt_q + cnt_t'(issue) - cnt_t'(pop);
      unfill_cnt_d = unfill_cnt_q + cnt_t'(issue) - cnt_t'(fill);
      drop_cnt_d   = drop_cnt_q - cnt_t'(drop_dec);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q   <= PC_RST;
      alloc_ptr_q  <= '0;
      fill_ptr_q   <= '0;
      head_ptr_q   <= '0;
      alloc_cnt_q  <= '0;
      unfill_cnt_q <= '0;
      drop_cnt_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      alloc_ptr_q  <= alloc_ptr_d;
      fill_ptr_q   <= fill_ptr_d;
      head_ptr_q   <= head_ptr_d;
      alloc_cnt_q  <= alloc_cnt_d;
      unfill_cnt_q <= unfill_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      err_q        <= err_d;
    end
  end

  // Issue, fill and pop always address distinct entries, so they can coexist.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filled_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else if (redir_valid) begin
      filled_q <= '0;
    end else begin
      if (issue) pc_q[alloc_ptr_q] <= fetch_pc_q;
      if (fill) begin
        data_q[fill_ptr_q]   <= imem_rdata;
        filled_q[fill_ptr_q] <= 1'b1;
      end
      if (pop) filled_q[head_ptr_q] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a default instance exercised through several scenarios
// and a RESET_PC=0xFFE instance streaming continuously to cover address wrap.
module tb_fetch_unit;
  localparam int unsigned AW = 12;
  localparam int unsigned IW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en, redir_valid, inst_ready;
  logic [AW-1:0] redir_target;
  logic          imem_req, imem_rvalid, inst_valid, err;
  logic [AW-1:0] imem_addr, inst_pc;
  logic [IW-1:0] imem_rdata, inst_data;

  logic          w_req, w_rvalid, w_valid, w_err;
  logic [AW-1:0] w_addr, w_pc;
  logic [IW-1:0] w_rdata, w_data;

  int unsigned n_cmp = 0, n_bad = 0;
  int unsigned n_req = 0, n_pop = 0, w_pop = 0;
  int unsigned p0, r0;
  bit          saw_wrap = 1'b0;
  int          lat = 1;
  logic        inj = 1'b0;
  logic [AW-1:0] exp_pc, w_exp_pc;
  logic [AW-1:0] q[$];
  logic [AW-1:0] wq[$];

  fetch_unit dut (
    .clk(clk), .rst(rst), .en(en), .redir_valid(redir_valid), .redir_target(redir_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc), .err(err)
  );

  fetch_unit #(.RESET_PC(12'hFFE)) dut_w (
    .clk(clk), .rst(rst), .en(1'b1), .redir_valid(1'b0), .redir_target(12'h000),
    .imem_req(w_req), .imem_addr(w_addr), .imem_rvalid(w_rvalid),
    .imem_rdata(w_rdata), .inst_valid(w_valid), .inst_ready(1'b1),
    .inst_data(w_data), .inst_pc(w_pc), .err(w_err)
  );

  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    return {20'hC0DE5, a};
  endfunction

  // In-order memory with selectable latency 1..4; held in reset with the DUT.
  logic [3:0]    st_v;
  logic [AW-1:0] st_a [4];
  always @(posedge clk or posedge rst) begin
    if (rst) st_v <= '0;
    else begin
      st_v     <= {st_v[2:0], imem_req};
      st_a[0]  <= imem_addr;
      for (int i = 1; i < 4; i++) st_a[i] <= st_a[i-1];
    end
  end
  assign imem_rvalid = st_v[lat-1] | inj;
  assign imem_rdata  = inj ? 32'hDEAD_BEEF : mem_word(st_a[lat-1]);

  logic          wm_v;
  logic [AW-1:0] wm_a;
  always @(posedge clk or posedge rst) begin
    if (rst) wm_v <= 1'b0;
    else begin
      wm_v <= w_req;
      wm_a <= w_addr;
    end
  end
  assign w_rvalid = wm_v;
  assign w_rdata  = mem_word(wm_a);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int new_lat);
    rst = 1'b1;
    #1 lat = new_lat;
    tick(2);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin : mon
    logic [AW-1:0] pc;
    if (rst) begin
      q.delete();
      exp_pc = 12'h000;
    end else if (redir_valid) begin
      check_eq("redir_no_req", 32'(imem_req), 32'd0);
      check_eq("redir_no_valid", 32'(inst_valid), 32'd0);
      q.delete();
      exp_pc = redir_target;
    end else begin
      if (inst_valid && inst_ready) begin
        check_eq("pop_expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          pc = q.pop_front();
          check_eq("inst_pc", 32'(inst_pc), 32'(pc));
          check_eq("inst_data", inst_data, mem_word(pc));
        end
        n_pop++;
      end
      if (imem_req) begin
        check_eq("imem_addr", 32'(imem_addr), 32'(exp_pc));
        q.push_back(exp_pc);
        exp_pc = exp_pc + 12'd1;
        n_req++;
      end
    end
  end

  always @(negedge clk) begin : mon_w
    logic [AW-1:0] pc;
    if (rst) begin
      wq.delete();
      w_exp_pc = 12'hFFE;
    end else begin
      if (w_valid) begin
        check_eq("w_pop_expected", 32'(wq.size() != 0), 32'd1);
        if (wq.size() != 0) begin
          pc = wq.pop_front();
          check_eq("w_inst_pc", 32'(w_pc), 32'(pc));
          check_eq("w_inst_data", w_data, mem_word(pc));
          if (pc == 12'h000) saw_wrap = 1'b1;
          w_pop++;
        end
      end
      if (w_req) begin
        check_eq("w_imem_addr", 32'(w_addr), 32'(w_exp_pc));
        wq.push_back(w_exp_pc);
        w_exp_pc = w_exp_pc + 12'd1;
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b1; inst_ready = 1'b1; redir_valid = 1'b0; redir_target = '0;
    #2;
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_valid", 32'(inst_valid), 32'd0);
    check_eq("rst_pc", 32'(inst_pc), 32'd0);
    check_eq("rst_data", inst_data, 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    tick(2);
    rst = 1'b0;

    // Streaming at latency 1: first instruction two cycles after the first request.
    @(negedge clk) check_eq("lat_c0_valid", 32'(inst_valid), 32'd0);
    check_eq("lat_c0_req", 32'(imem_req), 32'd1);
    @(negedge clk) check_eq("lat_c1_valid", 32'(inst_valid), 32'd0);
    @(negedge clk) check_eq("lat_c2_valid", 32'(inst_valid), 32'd1);
    check_eq("lat_c2_pc", 32'(inst_pc), 32'd0);
    tick(1);
    p0 = n_pop; r0 = n_req;
    tick(16);
    check_eq("stream_pops", n_pop - p0, 32'd16);
    check_eq("stream_reqs", n_req - r0, 32'd16);

    // Consumer stalled: buffer fills after four requests, then drains in order.
    inst_ready = 1'b0;
    do_reset(1);
    r0 = n_req;
    tick(10);
    check_eq("full_reqs", n_req - r0, 32'd4);
    check_eq("full_req_low", 32'(imem_req), 32'd0);
    check_eq("full_valid", 32'(inst_valid), 32'd1);
    check_eq("full_head_pc", 32'(inst_pc), 32'd0);
    inst_ready = 1'b1;
    p0 = n_pop; r0 = n_req;
    tick(10);
    check_eq("full_drained", 32'(n_pop - p0 >= 4), 32'd1);
    check_eq("full_resumed", 32'(n_req > r0), 32'd1);

    // Latency 3, redirect with two requests outstanding.
    do_reset(3);
    tick(2);
    redir_valid = 1'b1; redir_target = 12'h100;
    tick(1);
    redir_valid = 1'b0;
    p0 = n_pop;
    tick(12);
    check_eq("redir_pops", 32'(n_pop - p0 >= 2), 32'd1);
    check_eq("redir_err", 32'(err), 32'd0);

    // Stray response with nothing outstanding.
    inst_ready = 1'b0;
    do_reset(1);
    tick(8);
    check_eq("pre_inj_valid", 32'(inst_valid), 32'd1);
    inj = 1'b1;
    tick(1);
    inj = 1'b0;
    check_eq("inj_err", 32'(err), 32'd1);
    check_eq("inj_valid", 32'(inst_valid), 32'd1);
    check_eq("inj_pc", 32'(inst_pc), 32'd0);
    check_eq("inj_data", inst_data, mem_word(12'h000));
    en = 1'b0; inst_ready = 1'b1;
    p0 = n_pop;
    tick(8);
    check_eq("inj_pops", n_pop - p0, 32'd4);
    check_eq("inj_err_sticky", 32'(err), 32'd1);
    check_eq("inj_empty", 32'(inst_valid), 32'd0);

    // Asynchronous reset between clock edges.
    en = 1'b1;
    tick(6);
    check_eq("pre_arst_valid", 32'(inst_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_req", 32'(imem_req), 32'd0);
    check_eq("arst_valid", 32'(inst_valid), 32'd0);
    check_eq("arst_pc", 32'(inst_pc), 32'd0);
    check_eq("arst_data", inst_data, 32'd0);
    check_eq("arst_err", 32'(err), 32'd0);
    tick(1);
    rst = 1'b0;
    p0 = n_pop; r0 = n_req;
    tick(10);
    check_eq("arst_pops", n_pop - p0, 32'd8);
    check_eq("arst_reqs", n_req - r0, 32'd10);

    check_eq("w_wrap_seen", 32'(saw_wrap), 32'd1);
    check_eq("w_streamed", 32'(w_pop > 10), 32'd1);
    check_eq("w_err", 32'(w_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
